// File: rtl/controle_ajuste.sv
// rtl/controle_ajuste.sv - clock time-setting controller: button debounce, adjust FSM, strobes, blink
// Optional feature macro: AUTO_REPEAT_EN (held inc button auto-repeats its strobe).

module controle_ajuste_deb #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d, prev_q;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) level_d = sync_q[1];
      else                                   cnt_d   = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      prev_q  <= level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~prev_q;
endmodule

module controle_ajuste #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] BLINK_HALF      = 24'd250000,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd5000000,
  parameter logic [23:0] REPEAT_DELAY    = 24'd500000,
  parameter logic [23:0] REPEAT_RATE     = 24'd100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ajuste,
  input  logic       btn_inc,
  output logic [1:0] modo,
  output logic       run_en,
  output logic       inc_min,
  output logic       inc_hora,
  output logic       zera_seg,
  output logic       apaga_min,
  output logic       apaga_hora
);
  typedef enum logic [1:0] {NORMAL = 2'b00, AJ_MIN = 2'b01, AJ_HORA = 2'b10, ILEGAL = 2'b11} estado_t;

  estado_t     state_q, state_d;
  logic        aj_level, aj_press, inc_level, inc_press;
  logic        adj, busy, chg, strobe, inc_ok, rep_evt, tmo_hit;
  logic [31:0] tmo_q, tmo_d;
  logic [23:0] blk_q, blk_d;
  logic        phase_q, phase_d;
  logic        run_q, run_d, min_q, min_d, hora_q, hora_d, zera_q, zera_d;
  logic        apm_q, apm_d, aph_q, aph_d;
  logic        unused_lvl;

  controle_ajuste_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_aj (
    .clk(clk), .reset(reset), .btn_i(btn_ajuste), .level_o(aj_level), .press_o(aj_press)
  );
  controle_ajuste_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .btn_i(btn_inc), .level_o(inc_level), .press_o(inc_press)
  );

  assign unused_lvl = aj_level;
  assign adj        = (state_q == AJ_MIN) || (state_q == AJ_HORA);
  assign inc_ok     = adj & inc_press & ~aj_press;
  assign strobe     = inc_ok | rep_evt;
  // Pending inc activity takes priority over an expiring timeout.
  assign busy       = inc_press | rep_evt;
  assign tmo_hit    = !busy && (tmo_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL:  if (aj_press) state_d = AJ_MIN;
      AJ_MIN:  if (aj_press) state_d = AJ_HORA;
               else if (tmo_hit) state_d = NORMAL;
      AJ_HORA: if (aj_press || tmo_hit) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  assign chg = (state_d != state_q);

  always_comb begin
    tmo_d = tmo_q + 32'd1;
    if (chg || !adj || aj_press || busy) tmo_d = '0;
    blk_d   = blk_q + 24'd1;
    phase_d = phase_q;
    if (chg || !adj || strobe) begin
      blk_d   = '0;
      phase_d = 1'b0;
    end else if (blk_q == BLINK_HALF - 24'd1) begin
      blk_d   = '0;
      phase_d = ~phase_q;
    end
    run_d  = (state_d == NORMAL);
    min_d  = strobe && (state_q == AJ_MIN);
    hora_d = strobe && (state_q == AJ_HORA);
    zera_d = adj && (state_d == NORMAL);
    apm_d  = phase_d && (state_d == AJ_MIN);
    aph_d  = phase_d && (state_d == AJ_HORA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      tmo_q   <= '0;
      blk_q   <= '0;
      phase_q <= 1'b0;
      run_q   <= 1'b1;
      min_q   <= 1'b0;
      hora_q  <= 1'b0;
      zera_q  <= 1'b0;
      apm_q   <= 1'b0;
      aph_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      blk_q   <= blk_d;
      phase_q <= phase_d;
      run_q   <= run_d;
      min_q   <= min_d;
      hora_q  <= hora_d;
      zera_q  <= zera_d;
      apm_q   <= apm_d;
      aph_q   <= aph_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic [23:0] rep_cnt_q, rep_cnt_d;
  logic        rep_act_q, rep_act_d, rep_first_q, rep_first_d;

  assign rep_evt = rep_act_q && inc_level && adj && !aj_press &&
                   (rep_cnt_q == (rep_first_q ? REPEAT_DELAY : REPEAT_RATE) - 24'd1);

  always_comb begin
    rep_cnt_d   = rep_cnt_q + 24'd1;
    rep_act_d   = rep_act_q;
    rep_first_d = rep_first_q;
    if (inc_ok) begin
      rep_cnt_d   = '0;
      rep_act_d   = 1'b1;
      rep_first_d = 1'b1;
    end else if (!rep_act_q || !inc_level || aj_press || chg) begin
      rep_cnt_d   = '0;
      rep_act_d   = 1'b0;
      rep_first_d = 1'b0;
    end else if (rep_evt) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  logic unused_rep;
  assign rep_evt    = 1'b0;
  assign unused_rep = ^{REPEAT_DELAY, REPEAT_RATE, inc_level};
`endif

  assign modo       = state_q;
  assign run_en     = run_q;
  assign inc_min    = min_q;
  assign inc_hora   = hora_q;
  assign zera_seg   = zera_q;
  assign apaga_min  = apm_q;
  assign apaga_hora = aph_q;
endmodule

// File: tb/tb_controle_ajuste.sv
// tb/tb_controle_ajuste.sv - scoreboard bench for controle_ajuste
module tb_controle_ajuste;
  localparam int K_MODO = 0, K_RUN = 1, K_MIN = 2, K_HORA = 3, K_ZERA = 4, K_APH = 5;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_ajuste, btn_inc;
  logic [1:0] modo;
  logic       run_en, inc_min, inc_hora, zera_seg, apaga_min, apaga_hora;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  bit  watch_blink = 1'b0;
  ev_t exp_q[$];

  logic [1:0] p_modo = 2'b00;
  logic       p_run = 1'b1;
  logic       p_aph = 1'b0;

  controle_ajuste #(
    .DEBOUNCE_CYCLES(16'd4),
    .BLINK_HALF(24'd8),
    .TIMEOUT_CYCLES(32'd100),
    .REPEAT_DELAY(24'd20),
    .REPEAT_RATE(24'd5)
  ) dut (
    .clk(clk), .reset(reset), .btn_ajuste(btn_ajuste), .btn_inc(btn_inc),
    .modo(modo), .run_en(run_en), .inc_min(inc_min), .inc_hora(inc_hora),
    .zera_seg(zera_seg), .apaga_min(apaga_min), .apaga_hora(apaga_hora)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_MODO:  return "modo";
      K_RUN:   return "run_en";
      K_MIN:   return "inc_min";
      K_HORA:  return "inc_hora";
      K_ZERA:  return "zera_seg";
      default: return "apaga_hora";
    endcase
  endfunction

  task automatic push(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input int v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required no event", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL event_order: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                 kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic check_eq(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (modo != p_modo) check_ev(K_MODO, int'(modo));
      if (run_en != p_run) check_ev(K_RUN, int'(run_en));
      if (inc_min) check_ev(K_MIN, 1);
      if (inc_hora) check_ev(K_HORA, 1);
      if (zera_seg) check_ev(K_ZERA, 1);
      if (watch_blink && apaga_hora != p_aph) check_ev(K_APH, int'(apaga_hora));
    end
    p_modo = modo;
    p_run  = run_en;
    p_aph  = apaga_hora;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_btn(input logic aj, input logic inc, input int n);
    btn_ajuste = aj;
    btn_inc    = inc;
    repeat (n) @(negedge clk);
    btn_ajuste = 1'b0;
    btn_inc    = 1'b0;
  endtask

  initial begin
    int t, e, last;
    reset = 1'b1;
    btn_ajuste = 1'b0;
    btn_inc = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(1);
    check_eq("reset_modo", int'(modo), 0);
    check_eq("reset_run_en", int'(run_en), 1);
    check_eq("reset_inc_min", int'(inc_min), 0);
    check_eq("reset_inc_hora", int'(inc_hora), 0);
    check_eq("reset_zera_seg", int'(zera_seg), 0);
    check_eq("reset_apaga_min", int'(apaga_min), 0);
    check_eq("reset_apaga_hora", int'(apaga_hora), 0);
    mon_en = 1'b1;

    // Mode cycle NORMAL -> AJ_MIN -> AJ_HORA -> NORMAL
    t = cyc; push(t + 7, K_MODO, 1); push(t + 7, K_RUN, 0);
    hold_btn(1'b1, 1'b0, 10); idle(25);
    t = cyc; push(t + 7, K_MODO, 2);
    hold_btn(1'b1, 1'b0, 10); idle(25);
    t = cyc; push(t + 7, K_MODO, 0); push(t + 7, K_RUN, 1); push(t + 7, K_ZERA, 1);
    hold_btn(1'b1, 1'b0, 10); idle(25);

    // Short glitch and inc presses in NORMAL: no events expected
    hold_btn(1'b1, 1'b0, 3); idle(20);
    for (int i = 0; i < 3; i++) begin
      hold_btn(1'b0, 1'b1, 10); idle(20);
    end

    // Three inc presses in AJ_MIN
    t = cyc; push(t + 7, K_MODO, 1); push(t + 7, K_RUN, 0);
    hold_btn(1'b1, 1'b0, 10); idle(25);
    for (int i = 0; i < 3; i++) begin
      t = cyc; push(t + 7, K_MIN, 1);
      hold_btn(1'b0, 1'b1, 10); idle(15);
    end

    // Simultaneous presses, then timeout out of AJ_HORA with blink
    t = cyc; e = t + 7;
    push(e, K_MODO, 2);
    for (int k = 1; k <= 12; k++) push(e + 8 * k, K_APH, k % 2);
    push(e + 100, K_MODO, 0); push(e + 100, K_RUN, 1); push(e + 100, K_ZERA, 1);
    watch_blink = 1'b1;
    hold_btn(1'b1, 1'b1, 10);
    idle(e + 105 - cyc);
    watch_blink = 1'b0;

    // Held inc in AJ_MIN, then timeout
    t = cyc; push(t + 7, K_MODO, 1); push(t + 7, K_RUN, 0);
    hold_btn(1'b1, 1'b0, 10); idle(25);
    t = cyc;
    push(t + 7, K_MIN, 1);
`ifdef AUTO_REPEAT_EN
    push(t + 27, K_MIN, 1);
    push(t + 32, K_MIN, 1);
    push(t + 37, K_MIN, 1);
    push(t + 42, K_MIN, 1);
    last = t + 42;
`else
    last = t + 7;
`endif
    push(last + 100, K_MODO, 0); push(last + 100, K_RUN, 1); push(last + 100, K_ZERA, 1);
    hold_btn(1'b0, 1'b1, 40);
    idle(last + 110 - cyc);

    while (exp_q.size() > 0) begin
      ev_t m;
      m = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_event: got nothing, required %s=%0d at cycle %0d", kname(m.kind), m.val, m.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
